prim_arbiter_wrr: RTL

// N:1 weighted round-robin arbiter with a valid/ready output handshake. It is the successor of
// the single-grant round-robin arbiter. Each winning requestor keeps the grant for a burst of up
// to weight_i[n]+1 accepted beats before rotation. The winner is held while the sink stalls.
// It sits in front of shared sinks (bus ports, shared memories) where per-source bandwidth shares
// are programmed by CSRs.

---
 rtl/prim_arbiter_wrr.sv | 111 +++++++++++
 1 files changed

// File: rtl/prim_arbiter_wrr.sv
// N:1 weighted round-robin arbiter with a valid/ready output handshake.
// A winner keeps the grant for up to weight+1 accepted beats and is held while the sink stalls.
module prim_arbiter_wrr #(
  parameter int unsigned N          = 8,
  parameter int unsigned DW         = 32,
  parameter int unsigned WeightW    = 4,
  parameter bit          EnDataPort = 1'b1,
  parameter bit          EnWeight   = 1'b1,
  parameter int unsigned IdxW       = $clog2(N)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N-1:0]                  req_i,
  input  logic [N-1:0][WeightW-1:0]     weight_i,
  input  logic [N-1:0][DW-1:0]          data_i,
  output logic [N-1:0]                  gnt_o,
  output logic [IdxW-1:0]               idx_o,
  output logic                          valid_o,
  output logic [DW-1:0]                 data_o,
  input  logic                          ready_i,
  output logic                          burst_o
);

  logic [N-1:0]       mask_q;
  logic [IdxW-1:0]    cur_idx_q;
  logic [WeightW-1:0] cnt_q;
  logic               busy_q;
  logic               locked_q;

  logic               hold;
  logic               cont_burst;
  logic               accept;
  logic [N-1:0]       masked;
  logic [N-1:0]       arb_src;
  logic [IdxW-1:0]    arb_idx;
  logic [IdxW-1:0]    winner;
  logic [N-1:0]       above;
  logic [WeightW-1:0] new_cnt;

  assign valid_o    = |req_i;
  assign accept     = valid_o & ready_i;
  // A stalled or bursting winner keeps the port only while it still requests.
  assign hold       = (busy_q | locked_q) & req_i[cur_idx_q];
  assign cont_burst = busy_q & req_i[cur_idx_q];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    masked  = req_i & mask_q;
    arb_src = (|masked) ? masked : req_i;
    arb_idx = '0;
    // Descending scan: the last hit is the lowest set bit.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (arb_src[i]) arb_idx = IdxW'(i);
    end
    winner = hold ? cur_idx_q : arb_idx;

    above = '0;
    for (int i = 0; i < int'(N); i++) begin
      above[i] = (IdxW'(i) > winner);
    end

    gnt_o = '0;
    if (accept) gnt_o[winner] = 1'b1;
  end

  assign new_cnt = EnWeight ? weight_i[winner] : '0;
  assign idx_o   = valid_o ? winner : '0;
  assign data_o  = EnDataPort ? (valid_o ? data_i[idx_o] : '0) : '1;
  assign burst_o = busy_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q    <= '0;
      cur_idx_q <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      locked_q  <= 1'b0;
    end else if (accept) begin
      mask_q    <= above;
      locked_q  <= 1'b0;
      cur_idx_q <= winner;
      if (cont_burst) begin
        cnt_q  <= cnt_q - WeightW'(1);
        busy_q <= (cnt_q != WeightW'(1));
      end else begin
        cnt_q  <= new_cnt;
        busy_q <= (new_cnt != '0);
      end
    end else if (valid_o) begin
      cur_idx_q <= winner;
      locked_q  <= 1'b1;
    end else begin
      locked_q <= 1'b0;
      busy_q   <= 1'b0;
    end
  end

  a_gnt_onehot0: assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));
  a_gnt_req:     assert property (@(posedge clk_i) disable iff (!rst_ni) (gnt_o & ~req_i) == '0);
  a_gnt_ready:   assert property (@(posedge clk_i) disable iff (!rst_ni) (|gnt_o) |-> ready_i);
  a_accept_gnt:  assert property (@(posedge clk_i) disable iff (!rst_ni) (valid_o && ready_i) |-> (|gnt_o));
  a_stall_hold:  assert property (@(posedge clk_i) disable iff (!rst_ni)
                                  (valid_o && !ready_i) |=> (idx_o == $past(idx_o)));

  if (EnDataPort) begin : g_data_chk
    a_data_mux: assert property (@(posedge clk_i) disable iff (!rst_ni)
                                 valid_o |-> (data_o == data_i[idx_o]));
  end

endmodule
